// File: rtl/mem_initiator_if.sv
// Purpose: bundles the client request/ack/data signals and the memory command and read-data
//          signals of mem_initiator.
// Latency: none; this is wiring only.
// Backpressure: none here; each client holds its request until it sees its ack.
// Ports: slave = the initiator side (takes requests and read data, drives acks and commands);
//        master = the clients and memory side.
interface mem_initiator_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  iWrReq;
  logic [ADDR_WIDTH-1:0] iWrAddr;
  logic [DATA_WIDTH-1:0] iWrData;
  logic                  oWrAck;
  logic                  iRdReqA;
  logic [ADDR_WIDTH-1:0] iRdAddrA;
  logic                  oRdAckA;
  logic                  oRdValidA;
  logic [DATA_WIDTH-1:0] oRdDataA;
  logic                  iRdReqB;
  logic [ADDR_WIDTH-1:0] iRdAddrB;
  logic                  oRdAckB;
  logic                  oRdValidB;
  logic [DATA_WIDTH-1:0] oRdDataB;
  logic                  oAddrErr;
  logic                  oWriteEnable;
  logic                  oReadtoa;
  logic                  oReadtob;
  logic [ADDR_WIDTH-1:0] oAddress;
  logic [DATA_WIDTH-1:0] oDataOut;
  logic [DATA_WIDTH-1:0] iDataOuta;
  logic [DATA_WIDTH-1:0] iDataOutb;

  modport slave (
    input  iWrReq, iWrAddr, iWrData, iRdReqA, iRdAddrA, iRdReqB, iRdAddrB,
           iDataOuta, iDataOutb,
    output oWrAck, oRdAckA, oRdValidA, oRdDataA, oRdAckB, oRdValidB, oRdDataB,
           oAddrErr, oWriteEnable, oReadtoa, oReadtob, oAddress, oDataOut
  );

  modport master (
    output iWrReq, iWrAddr, iWrData, iRdReqA, iRdAddrA, iRdReqB, iRdAddrB,
           iDataOuta, iDataOutb,
    input  oWrAck, oRdAckA, oRdValidA, oRdDataA, oRdAckB, oRdValidB, oRdDataB,
           oAddrErr, oWriteEnable, oReadtoa, oReadtob, oAddress, oDataOut
  );
endinterface

// File: rtl/mem_initiator.sv
// Purpose: arbitrates one write client and two read clients onto a single-port memory's one-hot
//          command bus, and returns the registered read data to the client that asked for it.
// Latency: ack and command one cycle after the request is sampled in IDLE; read valid two cycles
//          after that.
// Backpressure: a request that loses arbitration, or arrives in CMD or CAPT, waits with no ack.
// Ports: Clock, Reset_n (asynchronous, active-low); bus (mem_initiator_if.slave) carries the
//        client requests and acks, the memory commands, and the memory read data.
// Build option: MEM_INITIATOR_RR_ARB_EN selects round-robin arbitration (W->A->B->W). When it is
//               undefined, arbitration is fixed priority W > A > B.
module mem_initiator #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_SIZE   = 10
) (
  input logic            Clock,
  input logic            Reset_n,
  mem_initiator_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CMD, CAPT} state_t;
  typedef enum logic [1:0] {CL_W = 2'd0, CL_A = 2'd1, CL_B = 2'd2} client_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(MEM_SIZE);

  state_t                state_q, state_d;
  client_t               client_q, client_d;
  logic                  wr_ack_q, wr_ack_d, rd_ack_a_q, rd_ack_a_d, rd_ack_b_q, rd_ack_b_d;
  logic                  addr_err_q, addr_err_d;
  logic                  we_q, we_d, rda_q, rda_d, rdb_q, rdb_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;
  logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;

  logic                  grant_vld;
  client_t               grant_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  in_range;

  assign grant_vld = bus.iWrReq | bus.iRdReqA | bus.iRdReqB;

`ifdef MEM_INITIATOR_RR_ARB_EN
  client_t last_q, last_d;

  // Search order starts with the client just after the last one granted.
  always_comb begin
    grant_id = CL_W;
    case (last_q)
      CL_W:    grant_id = bus.iRdReqA ? CL_A : (bus.iRdReqB ? CL_B : CL_W);
      CL_A:    grant_id = bus.iRdReqB ? CL_B : (bus.iWrReq  ? CL_W : CL_A);
      default: grant_id = bus.iWrReq  ? CL_W : (bus.iRdReqA ? CL_A : CL_B);
    endcase
  end
`else
  always_comb begin
    grant_id = bus.iWrReq ? CL_W : (bus.iRdReqA ? CL_A : CL_B);
  end
`endif

  always_comb begin
    case (grant_id)
      CL_A:    sel_addr = bus.iRdAddrA;
      CL_B:    sel_addr = bus.iRdAddrB;
      default: sel_addr = bus.iWrAddr;
    endcase
  end

  assign in_range = (sel_addr <= MAX_ADDR);

  // State register plus all registered outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      client_q     <= CL_W;
`ifdef MEM_INITIATOR_RR_ARB_EN
      last_q       <= CL_B;  // so that W is searched first after reset
`endif
      wr_ack_q     <= 1'b0;
      rd_ack_a_q   <= 1'b0;
      rd_ack_b_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      we_q         <= 1'b0;
      rda_q        <= 1'b0;
      rdb_q        <= 1'b0;
      address_q    <= '0;
      data_out_q   <= '0;
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
    end else begin
      state_q      <= state_d;
      client_q     <= client_d;
`ifdef MEM_INITIATOR_RR_ARB_EN
      last_q       <= last_d;
`endif
      wr_ack_q     <= wr_ack_d;
      rd_ack_a_q   <= rd_ack_a_d;
      rd_ack_b_q   <= rd_ack_b_d;
      addr_err_q   <= addr_err_d;
      we_q         <= we_d;
      rda_q        <= rda_d;
      rdb_q        <= rdb_d;
      address_q    <= address_d;
      data_out_q   <= data_out_d;
      rd_valid_a_q <= rd_valid_a_d;
      rd_valid_b_q <= rd_valid_b_d;
      rd_data_a_q  <= rd_data_a_d;
      rd_data_b_q  <= rd_data_b_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    client_d = client_q;
`ifdef MEM_INITIATOR_RR_ARB_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d  = CMD;
          client_d = grant_id;
`ifdef MEM_INITIATOR_RR_ARB_EN
          last_d   = grant_id;
`endif
        end
      end
      // An out-of-range read issues no command, so there is nothing to capture.
      CMD:     state_d = (client_q != CL_W && !addr_err_q) ? CAPT : IDLE;
      CAPT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Every output is computed one cycle early so that it is a flop output. As a
  // result, commands and acks are high only in CMD.
  always_comb begin
    wr_ack_d     = 1'b0;
    rd_ack_a_d   = 1'b0;
    rd_ack_b_d   = 1'b0;
    addr_err_d   = 1'b0;
    we_d         = 1'b0;
    rda_d        = 1'b0;
    rdb_d        = 1'b0;
    address_d    = '0;
    data_out_d   = '0;
    rd_valid_a_d = 1'b0;
    rd_valid_b_d = 1'b0;
    rd_data_a_d  = rd_data_a_q;
    rd_data_b_d  = rd_data_b_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          wr_ack_d   = (grant_id == CL_W);
          rd_ack_a_d = (grant_id == CL_A);
          rd_ack_b_d = (grant_id == CL_B);
          addr_err_d = !in_range;
          if (in_range) begin
            we_d       = (grant_id == CL_W);
            rda_d      = (grant_id == CL_A);
            rdb_d      = (grant_id == CL_B);
            address_d  = sel_addr;
            data_out_d = (grant_id == CL_W) ? bus.iWrData : '0;
          end
        end
      end
      CAPT: begin
        if (client_q == CL_A) begin
          rd_data_a_d  = bus.iDataOuta;
          rd_valid_a_d = 1'b1;
        end else begin
          rd_data_b_d  = bus.iDataOutb;
          rd_valid_b_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.oWrAck       = wr_ack_q;
  assign bus.oRdAckA      = rd_ack_a_q;
  assign bus.oRdAckB      = rd_ack_b_q;
  assign bus.oAddrErr     = addr_err_q;
  assign bus.oWriteEnable = we_q;
  assign bus.oReadtoa     = rda_q;
  assign bus.oReadtob     = rdb_q;
  assign bus.oAddress     = address_q;
  assign bus.oDataOut     = data_out_q;
  assign bus.oRdValidA    = rd_valid_a_q;
  assign bus.oRdValidB    = rd_valid_b_q;
  assign bus.oRdDataA     = rd_data_a_q;
  assign bus.oRdDataB     = rd_data_b_q;

endmodule
